// File: rtl/swo_uart_rx.sv
// SWO receiver in NRZ/UART mode: synchronizes the SWO pin, deframes characters
// using a bit-period down-counter and strobes one byte per valid frame.
module swo_uart_rx #(
  parameter int pSYNC_STAGES = 2,
  parameter int pMIN_DIV     = 3
) (
  input  logic       trace_clk,
  input  logic       reset_i,
  input  logic       I_swo,
  input  logic       I_swo_enable,
  input  logic [7:0] I_bitrate_div,
  input  logic [1:0] I_stop_bits,
  input  logic [3:0] I_data_bits,
  output logic [7:0] O_data,
  output logic       O_data_valid,
  output logic       O_frame_err,
  output logic       O_busy
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge
  // START | counting down to the start-bit midpoint
  // DATA  | sampling data bits, LSB first
  // STOP  | sampling one or two stop bits
  // BREAK | stop bit was low, waiting for the line to return high
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam logic [7:0] lpMIN_DIV = 8'(pMIN_DIV);

  logic [pSYNC_STAGES-1:0] r_sync;
  logic                    r_swo_d;
  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic [7:0]              r_div_e;
  logic [3:0]              r_nbits;
  logic                    r_two_stop;
  logic [3:0]              r_idx;
  logic                    r_stop_idx;
  logic [7:0]              r_shift;
  logic [7:0]              r_data;
  logic                    r_valid;
  logic                    r_err;

  logic       w_swo_s;
  logic       w_fall;
  logic [7:0] w_div_e;
  logic [8:0] w_period;
  logic [7:0] w_half;
  logic [3:0] w_nbits;
  logic       w_two_stop;
  logic [7:0] w_mask;

  assign w_swo_s    = r_sync[pSYNC_STAGES-1];
  assign w_fall     = r_swo_d & ~w_swo_s;
  assign w_div_e    = (I_bitrate_div < lpMIN_DIV) ? lpMIN_DIV : I_bitrate_div;
  assign w_period   = {1'b0, w_div_e} + 9'd1;
  assign w_half     = w_period[8:1];
  assign w_nbits    = (I_data_bits >= 4'd1 && I_data_bits <= 4'd8) ? I_data_bits : 4'd8;
  assign w_two_stop = (I_stop_bits >= 2'd2);
  assign w_mask     = 8'hFF >> (4'd8 - r_nbits);

  always_ff @(posedge trace_clk) begin
    if (reset_i) begin
      r_sync  <= '1;
      r_swo_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[pSYNC_STAGES-2:0], I_swo};
      r_swo_d <= w_swo_s;
    end
  end

  always_ff @(posedge trace_clk) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_div_e    <= lpMIN_DIV;
      r_nbits    <= 4'd8;
      r_two_stop <= 1'b0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      // Disabling drops any frame in flight, including a strobe due next cycle.
      if (!I_swo_enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_fall) begin
              r_state    <= ST_START;
              r_cnt      <= w_half;
              r_div_e    <= w_div_e;
              r_nbits    <= w_nbits;
              r_two_stop <= w_two_stop;
              r_shift    <= '0;
            end
          end
          ST_START: begin
            if (r_cnt == 8'd0) begin
              if (w_swo_s) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_DATA;
                r_cnt   <= r_div_e;
                r_idx   <= '0;
              end
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          ST_DATA: begin
            if (r_cnt == 8'd0) begin
              r_shift[r_idx[2:0]] <= w_swo_s;
              r_cnt               <= r_div_e;
              if (r_idx == r_nbits - 4'd1) begin
                r_state    <= ST_STOP;
                r_stop_idx <= 1'b0;
              end else begin
                r_idx <= r_idx + 4'd1;
              end
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          ST_STOP: begin
            if (r_cnt == 8'd0) begin
              if (!w_swo_s) begin
                r_err   <= 1'b1;
                r_state <= ST_BREAK;
              end else if (!r_two_stop || r_stop_idx) begin
                r_data  <= r_shift & w_mask;
                r_valid <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_stop_idx <= 1'b1;
                r_cnt      <= r_div_e;
              end
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          ST_BREAK: begin
            if (w_swo_s) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign O_data       = r_data;
  assign O_data_valid = r_valid;
  assign O_frame_err  = r_err;
  assign O_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_swo_uart_rx.sv
// Bench for swo_uart_rx: drives UART frames on the SWO pin and compares the
// received bytes, strobes and timing against a frame-level reference model.
module tb_swo_uart_rx;

  localparam int SYNC = 2;

  logic       trace_clk = 1'b0;
  logic       reset_i;
  logic       I_swo;
  logic       I_swo_enable;
  logic [7:0] I_bitrate_div;
  logic [1:0] I_stop_bits;
  logic [3:0] I_data_bits;
  logic [7:0] O_data;
  logic       O_data_valid;
  logic       O_frame_err;
  logic       O_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q_data[$];
  int         q_cyc[$];
  int         err_cnt = 0;
  int         overlap = 0;

  swo_uart_rx #(.pSYNC_STAGES(SYNC), .pMIN_DIV(3)) dut (
    .trace_clk    (trace_clk),
    .reset_i      (reset_i),
    .I_swo        (I_swo),
    .I_swo_enable (I_swo_enable),
    .I_bitrate_div(I_bitrate_div),
    .I_stop_bits  (I_stop_bits),
    .I_data_bits  (I_data_bits),
    .O_data       (O_data),
    .O_data_valid (O_data_valid),
    .O_frame_err  (O_frame_err),
    .O_busy       (O_busy)
  );

  always #5 trace_clk = ~trace_clk;

  always @(posedge trace_clk) cyc <= cyc + 1;

  always @(negedge trace_clk) begin
    if (O_data_valid) begin
      q_data.push_back(O_data);
      q_cyc.push_back(cyc);
    end
    if (O_frame_err) err_cnt++;
    if (O_data_valid && O_frame_err) overlap++;
  end

  function automatic int eff_p(input int div);
    return ((div < 3) ? 3 : div) + 1;
  endfunction

  function automatic int eff_nb(input int db);
    return (db >= 1 && db <= 8) ? db : 8;
  endfunction

  function automatic int eff_ns(input int sb);
    return (sb >= 2) ? 2 : 1;
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] d, input int nb);
    return 8'(int'(d) & ((1 << nb) - 1));
  endfunction

  function automatic logic [7:0] got_byte(input int i);
    return (q_data.size() > i) ? q_data[i] : 8'hxx;
  endfunction

  task automatic clear_mon();
    q_data.delete();
    q_cyc.delete();
    err_cnt = 0;
    overlap = 0;
  endtask

  task automatic set_cfg(input int div, input int sb, input int db);
    I_bitrate_div = 8'(div);
    I_stop_bits   = 2'(sb);
    I_data_bits   = 4'(db);
  endtask

  task automatic idle(input int n);
    I_swo = 1'b1;
    repeat (n) @(negedge trace_clk);
  endtask

  // Wire bit 0 is the start bit, then data LSB first, then stop bits.
  task automatic drive_frame(input logic [7:0] d, input int nb, input int ns, input int p,
                             input bit stop_ok, input int limit);
    for (int b = 0; b < 1 + nb + ns && b < limit; b++) begin
      if (b == 0) I_swo = 1'b0;
      else if (b <= nb) I_swo = d[b-1];
      else I_swo = stop_ok;
      repeat (p) @(negedge trace_clk);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    I_swo_enable = 1'b1;
    set_cfg(7, 1, 8);
    for (int i = 0; i < 12; i++) begin
      I_swo = 1'($urandom);
      @(negedge trace_clk);
      checks++;
      if ({O_data, O_data_valid, O_frame_err, O_busy} !== 11'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got data=%h v=%b e=%b busy=%b, want all 0",
                 i, O_data, O_data_valid, O_frame_err, O_busy);
      end
    end
    I_swo = 1'b1;
    @(negedge trace_clk);
    reset_i = 1'b0;
    clear_mon();
    idle(100);
    checks++;
    if ((q_data.size() + err_cnt) !== 0) begin
      errors++;
      $display("FAIL idle_no_strobe: got %0d valid %0d err, want 0", q_data.size(), err_cnt);
    end
    checks++;
    if (O_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b want 0", O_busy);
    end
  endtask

  task automatic test_basic();
    int c0, p, lat;
    set_cfg(7, 1, 8);
    p = eff_p(7);
    idle(5);
    clear_mon();
    c0 = cyc;
    drive_frame(8'hA5, 8, 1, p, 1'b1, 99);
    idle(10);
    checks++;
    if (q_data.size() !== 1) begin
      errors++;
      $display("FAIL basic_count: got %0d strobes want 1", q_data.size());
    end
    checks++;
    if (got_byte(0) !== 8'hA5) begin
      errors++;
      $display("FAIL basic_data: got %h want a5", got_byte(0));
    end
    // sync flops, edge-detect cycle, half-period count, start sample, then whole bits
    lat = SYNC + 2 + (p >> 1) + (8 + 1) * p;
    checks++;
    if (q_cyc.size() == 0 || q_cyc[0] - c0 !== lat) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d",
               (q_cyc.size() > 0) ? q_cyc[0] - c0 : -1, lat);
    end
  endtask

  task automatic test_frame_err();
    int not_busy;
    set_cfg(7, 1, 8);
    clear_mon();
    drive_frame(8'h3C, 8, 1, eff_p(7), 1'b0, 99);
    not_busy = 0;
    I_swo = 1'b0;
    repeat (50) begin
      @(negedge trace_clk);
      if (!O_busy) not_busy++;
    end
    checks++;
    if (not_busy !== 0) begin
      errors++;
      $display("FAIL ferr_busy_low: got %0d idle cycles while line low, want 0", not_busy);
    end
    checks++;
    if (err_cnt !== 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d want 1", err_cnt);
    end
    checks++;
    if (q_data.size() !== 0) begin
      errors++;
      $display("FAIL ferr_no_valid: got %0d want 0", q_data.size());
    end
    checks++;
    if (O_data !== 8'hA5) begin
      errors++;
      $display("FAIL ferr_data_hold: got %h want a5", O_data);
    end
    idle(6);
    checks++;
    if (O_busy !== 1'b0 || err_cnt !== 1) begin
      errors++;
      $display("FAIL ferr_release: got busy=%b errs=%0d want busy=0 errs=1", O_busy, err_cnt);
    end
  endtask

  task automatic test_glitch();
    int busy_cyc;
    set_cfg(15, 1, 8);
    idle(4);
    clear_mon();
    busy_cyc = 0;
    I_swo = 1'b0;
    repeat (2) @(negedge trace_clk);
    I_swo = 1'b1;
    repeat (40) begin
      @(negedge trace_clk);
      if (O_busy) busy_cyc++;
    end
    checks++;
    if ((busy_cyc >= 1 && busy_cyc <= 9) !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy cycles want 1..9", busy_cyc);
    end
    checks++;
    if ((q_data.size() + err_cnt) !== 0) begin
      errors++;
      $display("FAIL glitch_strobe: got %0d valid %0d err want 0", q_data.size(), err_cnt);
    end
  endtask

  task automatic test_config_b2b();
    int p;
    set_cfg(1, 2, 5);
    p = eff_p(1);
    idle(4);
    clear_mon();
    fork
      begin
        drive_frame(8'h1F, 5, 2, p, 1'b1, 99);
        drive_frame(8'h0A, 5, 2, p, 1'b1, 99);
      end
      begin
        repeat (10) @(negedge trace_clk);
        I_bitrate_div = 8'd9;
        repeat (10) @(negedge trace_clk);
        I_bitrate_div = 8'd1;
      end
    join
    idle(12);
    checks++;
    if (q_data.size() !== 2) begin
      errors++;
      $display("FAIL cfg_count: got %0d want 2", q_data.size());
    end
    checks++;
    if (got_byte(0) !== 8'h1F) begin
      errors++;
      $display("FAIL cfg_byte0: got %h want 1f", got_byte(0));
    end
    checks++;
    if (got_byte(1) !== 8'h0A) begin
      errors++;
      $display("FAIL cfg_byte1: got %h want 0a", got_byte(1));
    end
    checks++;
    if (q_cyc.size() < 2 || q_cyc[1] - q_cyc[0] !== (1 + 5 + 2) * p) begin
      errors++;
      $display("FAIL cfg_spacing: got %0d want %0d",
               (q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : -1, (1 + 5 + 2) * p);
    end
  endtask

  task automatic test_disable();
    int p;
    set_cfg(7, 1, 8);
    p = eff_p(7);
    idle(4);
    clear_mon();
    drive_frame(8'hC3, 8, 1, p, 1'b1, 4);
    I_swo = 1'b0;
    repeat (p / 2) @(negedge trace_clk);
    checks++;
    if (O_busy !== 1'b1) begin
      errors++;
      $display("FAIL dis_busy_before: got %b want 1", O_busy);
    end
    I_swo_enable = 1'b0;
    @(negedge trace_clk);
    checks++;
    if (O_busy !== 1'b0) begin
      errors++;
      $display("FAIL dis_idle_next: got busy=%b want 0", O_busy);
    end
    I_swo = 1'b1;
    repeat (p) @(negedge trace_clk);
    I_swo = 1'b0;
    repeat (p) @(negedge trace_clk);
    idle(60);
    checks++;
    if ((q_data.size() + err_cnt) !== 0) begin
      errors++;
      $display("FAIL dis_no_strobe: got %0d valid %0d err want 0", q_data.size(), err_cnt);
    end
    I_swo_enable = 1'b1;
    idle(5);
    drive_frame(8'h55, 8, 1, p, 1'b1, 99);
    idle(10);
    checks++;
    if (q_data.size() !== 1 || got_byte(0) !== 8'h55) begin
      errors++;
      $display("FAIL dis_reenable: got %0d strobes data %h want 1 strobe 55",
               q_data.size(), got_byte(0));
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(7, 1, 8);
    idle(4);
    clear_mon();
    drive_frame(8'h81, 8, 1, eff_p(7), 1'b1, 4);
    reset_i = 1'b1;
    repeat (2) @(negedge trace_clk);
    checks++;
    if (O_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy: got %b want 0", O_busy);
    end
    reset_i = 1'b0;
    idle(100);
    checks++;
    if ((q_data.size() + err_cnt) !== 0 || O_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_no_strobe: got %0d valid %0d err data %h want 0 0 00",
               q_data.size(), err_cnt, O_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int div, sb, db, nb;
    idle(4);
    clear_mon();
    for (int f = 0; f < 24; f++) begin
      div = $urandom_range(0, 12);
      sb  = $urandom_range(0, 3);
      db  = $urandom_range(0, 15);
      d   = 8'($urandom);
      nb  = eff_nb(db);
      set_cfg(div, sb, db);
      exp_q.push_back(model_byte(d, nb));
      drive_frame(d, nb, eff_ns(sb), eff_p(div), 1'b1, 99);
      idle($urandom_range(0, 4));
    end
    idle(40);
    checks++;
    if (q_data.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d", q_data.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_byte(i) !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_byte%0d: got %h want %h", i, got_byte(i), exp_q[i]);
      end
    end
    checks++;
    if (err_cnt !== 0 || overlap !== 0) begin
      errors++;
      $display("FAIL rand_strobes: got %0d frame errors %0d overlaps want 0 0", err_cnt, overlap);
    end
  endtask

  initial begin
    I_swo = 1'b1;
    test_reset();
    test_basic();
    test_frame_err();
    test_glitch();
    test_config_b2b();
    test_disable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
